emu_run_ctrl: RTL and testbench

Next-generation emulator run/pause controller on the host-side control bus. It gates the model via run_mode, counts model ticks, and stops the model on any of four causes: host request, step-count expiry, tick-count compare match, or an enabled trigger. The trigger count is parametrised up to 256. It records the pause cause and the lowest-index firing trigger, raises a pause interrupt pulse, and owns the scan-chain DMA start and direction control.

---
 rtl/emu_run_ctrl_pkg.sv | 42 ++++
 rtl/emu_trig_unit.sv | 83 ++++++++
 rtl/emu_run_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_emu_run_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/emu_run_ctrl_pkg.sv
// ============================================================================
// Module      : emu_run_ctrl_pkg
// Description : Register map, pause-cause bit indices and FSM encoding for
//               the emulator run/pause controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package emu_run_ctrl_pkg;

    localparam int TRIG_MAX = 256;

    localparam logic [11:0] c_off_mode_ctrl   = 12'h000;
    localparam logic [11:0] c_off_step_cnt    = 12'h004;
    localparam logic [11:0] c_off_tick_cnt_lo = 12'h008;
    localparam logic [11:0] c_off_tick_cnt_hi = 12'h00C;
    localparam logic [11:0] c_off_scan_ctrl   = 12'h010;
    localparam logic [11:0] c_off_tick_cmp_lo = 12'h014;
    localparam logic [11:0] c_off_tick_cmp_hi = 12'h018;
    localparam logic [11:0] c_off_cmp_en      = 12'h01C;
    localparam logic [11:0] c_off_pause_cause = 12'h020;
    localparam logic [11:0] c_off_trig_first  = 12'h024;

    // Trigger banks are selected by address bits [11:8]
    localparam logic [3:0] c_bank_trig_stat = 4'h1;
    localparam logic [3:0] c_bank_trig_en   = 4'h2;
    localparam logic [3:0] c_bank_trig_edge = 4'h3;

    localparam int c_cause_host = 0;
    localparam int c_cause_step = 1;
    localparam int c_cause_trig = 2;
    localparam int c_cause_cmp  = 3;

    typedef enum logic [1:0] {
        ST_PAUSED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STOPPING = 2'd2
    } run_state_t;

endpackage

`default_nettype wire

// File: rtl/emu_trig_unit.sv
// ============================================================================
// Module      : emu_trig_unit
// Description : Trigger masking, optional rising-edge qualification
//               (EMU_TRIG_EDGE_EN), hit reduction, lowest-index priority
//               encode and pause-time capture of TRIG_STAT / TRIG_FIRST.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module emu_trig_unit #(
    parameter int TRIG_N = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TRIG_N-1:0] i_trig,
    input  logic [TRIG_N-1:0] i_trig_en,
`ifdef EMU_TRIG_EDGE_EN
    input  logic [TRIG_N-1:0] i_trig_edge,
`endif
    input  logic              i_capture,
    input  logic              i_clear_first,
    output logic              o_trig_hit,
    output logic [TRIG_N-1:0] o_trig_stat,
    output logic              o_first_valid,
    output logic [7:0]        o_first_idx
);

    logic [TRIG_N-1:0] w_armed;
    logic [TRIG_N-1:0] w_active;
    logic              w_first_valid;
    logic [7:0]        w_first_idx;
    logic [TRIG_N-1:0] r_trig_stat;
    logic              r_first_valid;
    logic [7:0]        r_first_idx;

    assign w_armed = i_trig & i_trig_en;

`ifdef EMU_TRIG_EDGE_EN
    logic [TRIG_N-1:0] r_trig_q;

    always_ff @(posedge clk) begin
        if (rst) r_trig_q <= '0;
        else     r_trig_q <= i_trig;
    end

    // Edge-flagged triggers only count on the cycle they rise
    assign w_active = w_armed & ~(i_trig_edge & r_trig_q);
`else
    assign w_active = w_armed;
`endif

    assign o_trig_hit = |w_active;

    always_comb begin
        w_first_valid = |w_armed;
        w_first_idx   = '0;
        for (int i = TRIG_N - 1; i >= 0; i--) begin
            if (w_armed[i]) w_first_idx = 8'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_stat   <= '0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
        end else if (i_capture) begin
            r_trig_stat   <= w_armed;
            r_first_valid <= w_first_valid;
            r_first_idx   <= w_first_idx;
        end else if (i_clear_first) begin
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
        end
    end

    assign o_trig_stat   = r_trig_stat;
    assign o_first_valid = r_first_valid;
    assign o_first_idx   = r_first_idx;

endmodule

`default_nettype wire

// File: rtl/emu_run_ctrl.sv
// ============================================================================
// Module      : emu_run_ctrl
// Description : Emulator run/pause controller: tick/step counting, compare
//               and trigger stops, pause-cause capture, scan DMA control.
//               Optional rising-edge triggers under EMU_TRIG_EDGE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module emu_run_ctrl
    import emu_run_ctrl_pkg::*;
#(
    parameter  int TRIG_COUNT = 1,
    localparam int TRIG_N     = (TRIG_COUNT < 1) ? 1 :
                                ((TRIG_COUNT > TRIG_MAX) ? TRIG_MAX : TRIG_COUNT),
    localparam int TRIG_WORDS = (TRIG_N + 31) / 32
) (
    input  logic              host_clk,
    input  logic              host_rst,
    input  logic              tick,
    input  logic              model_busy,
    input  logic [TRIG_N-1:0] trig,
    input  logic              ctrl_wen,
    input  logic [11:0]       ctrl_waddr,
    input  logic [31:0]       ctrl_wdata,
    input  logic              ctrl_ren,
    input  logic [11:0]       ctrl_raddr,
    output logic [31:0]       ctrl_rdata,
    output logic              run_mode,
    output logic              scan_mode,
    output logic              pause_irq,
    output logic              dma_start,
    output logic              dma_direction,
    input  logic              dma_running
);

    localparam int c_pad = TRIG_WORDS * 32 - TRIG_N;

    run_state_t r_state, w_state_nxt;
    logic [31:0] r_step_cnt;
    logic [63:0] r_tick_cnt, r_tick_cmp;
    logic        r_cmp_en, r_scan, r_dma_dir, r_pause_irq;
    logic [3:0]  r_pause_cause;
    logic [TRIG_N-1:0] r_trig_en, r_trig_edge, w_trig_stat;
    logic [TRIG_WORDS-1:0][31:0] w_stat_pad, w_en_pad, w_edge_pad;

    logic [11:0] w_wa, w_ra;
    logic        w_mode_wr, w_scan_wr, w_start_req, w_run_mode, w_stopping;
    logic        w_step_hit, w_cmp_hit, w_trig_hit, w_pause_now;
    logic        w_first_valid;
    logic [7:0]  w_first_idx;
    logic [3:0]  w_cause;
    logic        w_unused;

    assign w_unused = &{1'b0, ctrl_ren, ctrl_waddr[1:0], ctrl_raddr[1:0]};

    assign w_wa        = {ctrl_waddr[11:2], 2'b00};
    assign w_ra        = {ctrl_raddr[11:2], 2'b00};
    assign w_run_mode  = (r_state != ST_PAUSED);
    assign w_stopping  = (r_state == ST_STOPPING);
    assign w_mode_wr   = ctrl_wen && (w_wa == c_off_mode_ctrl);
    assign w_scan_wr   = ctrl_wen && (w_wa == c_off_scan_ctrl);
    assign w_start_req = w_mode_wr && ctrl_wdata[0] && !dma_running;

    assign w_step_hit  = (r_step_cnt == 32'd1);
    assign w_cmp_hit   = r_cmp_en && ((r_tick_cnt + 64'd1) == r_tick_cmp);
    assign w_pause_now = w_run_mode && tick &&
                         (w_step_hit || w_cmp_hit || w_trig_hit || w_stopping);

    always_comb begin
        w_cause               = '0;
        w_cause[c_cause_host] = w_stopping;
        w_cause[c_cause_step] = w_step_hit;
        w_cause[c_cause_trig] = w_trig_hit;
        w_cause[c_cause_cmp]  = w_cmp_hit;
    end

`ifndef EMU_TRIG_EDGE_EN
    assign r_trig_edge = '0;
`endif

    emu_trig_unit #(.TRIG_N(TRIG_N)) u_trig (
        .clk           (host_clk),
        .rst           (host_rst),
        .i_trig        (trig),
        .i_trig_en     (r_trig_en),
`ifdef EMU_TRIG_EDGE_EN
        .i_trig_edge   (r_trig_edge),
`endif
        .i_capture     (w_pause_now),
        .i_clear_first (!w_run_mode && w_start_req),
        .o_trig_hit    (w_trig_hit),
        .o_trig_stat   (w_trig_stat),
        .o_first_valid (w_first_valid),
        .o_first_idx   (w_first_idx)
    );

    // A pause always beats a concurrent host write
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_PAUSED:   if (w_start_req) w_state_nxt = ST_RUNNING;
            ST_RUNNING:  if (w_pause_now) w_state_nxt = ST_PAUSED;
                         else if (w_mode_wr && !ctrl_wdata[0]) w_state_nxt = ST_STOPPING;
            ST_STOPPING: if (w_pause_now) w_state_nxt = ST_PAUSED;
            default:     w_state_nxt = ST_PAUSED;
        endcase
    end

    always_ff @(posedge host_clk) begin
        if (host_rst) begin
            r_state       <= ST_PAUSED;
            r_step_cnt    <= '0;
            r_tick_cnt    <= '0;
            r_tick_cmp    <= '0;
            r_cmp_en      <= 1'b0;
            r_scan        <= 1'b0;
            r_dma_dir     <= 1'b0;
            r_pause_irq   <= 1'b0;
            r_pause_cause <= '0;
            r_trig_en     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pause_irq <= w_pause_now;
            if (w_run_mode) begin
                if (tick) begin
                    r_tick_cnt <= r_tick_cnt + 64'd1;
                    if (r_step_cnt != 32'd0) r_step_cnt <= r_step_cnt - 32'd1;
                end
            end else if (ctrl_wen) begin
                if (w_wa == c_off_step_cnt)    r_step_cnt        <= ctrl_wdata;
                if (w_wa == c_off_tick_cnt_lo) r_tick_cnt[31:0]  <= ctrl_wdata;
                if (w_wa == c_off_tick_cnt_hi) r_tick_cnt[63:32] <= ctrl_wdata;
                if (w_wa == c_off_tick_cmp_lo) r_tick_cmp[31:0]  <= ctrl_wdata;
                if (w_wa == c_off_tick_cmp_hi) r_tick_cmp[63:32] <= ctrl_wdata;
                if (w_wa == c_off_cmp_en)      r_cmp_en          <= ctrl_wdata[0];
                if (w_mode_wr && !(ctrl_wdata[0] && dma_running)) r_scan <= ctrl_wdata[1];
            end
            if (w_scan_wr && !dma_running) r_dma_dir <= ctrl_wdata[1];
            if (w_pause_now)                    r_pause_cause <= w_cause;
            else if (!w_run_mode && w_start_req) r_pause_cause <= '0;
            for (int i = 0; i < TRIG_N; i++) begin
                if (ctrl_wen && w_wa[11:8] == c_bank_trig_en && w_wa[7:2] == 6'(i / 32))
                    r_trig_en[i] <= ctrl_wdata[i % 32];
            end
        end
    end

`ifdef EMU_TRIG_EDGE_EN
    always_ff @(posedge host_clk) begin
        if (host_rst) begin
            r_trig_edge <= '0;
        end else begin
            for (int i = 0; i < TRIG_N; i++) begin
                if (ctrl_wen && w_wa[11:8] == c_bank_trig_edge && w_wa[7:2] == 6'(i / 32))
                    r_trig_edge[i] <= ctrl_wdata[i % 32];
            end
        end
    end
`endif

    generate
        if (c_pad > 0) begin : g_pad
            assign w_stat_pad = {{c_pad{1'b0}}, w_trig_stat};
            assign w_en_pad   = {{c_pad{1'b0}}, r_trig_en};
            assign w_edge_pad = {{c_pad{1'b0}}, r_trig_edge};
        end else begin : g_nopad
            assign w_stat_pad = w_trig_stat;
            assign w_en_pad   = r_trig_en;
            assign w_edge_pad = r_trig_edge;
        end
    endgenerate

    always_comb begin
        ctrl_rdata = '0;
        case (w_ra)
            c_off_mode_ctrl:   ctrl_rdata = {28'd0, model_busy, w_stopping, r_scan, w_run_mode};
            c_off_step_cnt:    ctrl_rdata = r_step_cnt;
            c_off_tick_cnt_lo: ctrl_rdata = r_tick_cnt[31:0];
            c_off_tick_cnt_hi: ctrl_rdata = r_tick_cnt[63:32];
            c_off_scan_ctrl:   ctrl_rdata = {30'd0, r_dma_dir, dma_running};
            c_off_tick_cmp_lo: ctrl_rdata = r_tick_cmp[31:0];
            c_off_tick_cmp_hi: ctrl_rdata = r_tick_cmp[63:32];
            c_off_cmp_en:      ctrl_rdata = {31'd0, r_cmp_en};
            c_off_pause_cause: ctrl_rdata = {28'd0, r_pause_cause};
            c_off_trig_first:  ctrl_rdata = {w_first_valid, 23'd0, w_first_idx};
            default: begin
                for (int k = 0; k < TRIG_WORDS; k++) begin
                    if (w_ra[7:2] == 6'(k)) begin
                        if (w_ra[11:8] == c_bank_trig_stat) ctrl_rdata = w_stat_pad[k];
                        if (w_ra[11:8] == c_bank_trig_en)   ctrl_rdata = w_en_pad[k];
                        if (w_ra[11:8] == c_bank_trig_edge) ctrl_rdata = w_edge_pad[k];
                    end
                end
            end
        endcase
    end

    assign run_mode      = w_run_mode;
    assign scan_mode     = r_scan;
    assign pause_irq     = r_pause_irq;
    assign dma_direction = r_dma_dir;
    assign dma_start     = w_scan_wr && ctrl_wdata[0] && !w_run_mode;

endmodule

`default_nettype wire

// File: tb/tb_emu_run_ctrl.sv
// ============================================================================
// Module      : tb_emu_run_ctrl
// Description : Directed self-checking bench for emu_run_ctrl (70 triggers);
//               adds the edge-trigger scenario when EMU_TRIG_EDGE_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_emu_run_ctrl;

    logic        host_clk = 1'b0;
    logic        host_rst, tick, model_busy, ctrl_wen, ctrl_ren, dma_running;
    logic [69:0] trig;
    logic [11:0] ctrl_waddr, ctrl_raddr;
    logic [31:0] ctrl_wdata, ctrl_rdata;
    logic        run_mode, scan_mode, pause_irq, dma_start, dma_direction;
    int          checks = 0;
    int          failures = 0;

    always #5 host_clk = ~host_clk;

    emu_run_ctrl #(.TRIG_COUNT(70)) dut (
        .host_clk(host_clk), .host_rst(host_rst), .tick(tick), .model_busy(model_busy),
        .trig(trig), .ctrl_wen(ctrl_wen), .ctrl_waddr(ctrl_waddr), .ctrl_wdata(ctrl_wdata),
        .ctrl_ren(ctrl_ren), .ctrl_raddr(ctrl_raddr), .ctrl_rdata(ctrl_rdata),
        .run_mode(run_mode), .scan_mode(scan_mode), .pause_irq(pause_irq),
        .dma_start(dma_start), .dma_direction(dma_direction), .dma_running(dma_running)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge host_clk);
        ctrl_wen = 1'b1; ctrl_waddr = a; ctrl_wdata = d;
        @(negedge host_clk);
        ctrl_wen = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        ctrl_raddr = a; ctrl_ren = 1'b1;
        #1;
        chk(tag, {32'd0, ctrl_rdata}, {32'd0, exp});
        ctrl_ren = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge host_clk); tick = 1'b1;
            @(negedge host_clk); tick = 1'b0;
        end
    endtask

    initial begin
        host_rst = 1'b1; tick = 0; model_busy = 0; trig = '0; ctrl_wen = 0; ctrl_ren = 0;
        ctrl_waddr = '0; ctrl_raddr = '0; ctrl_wdata = '0; dma_running = 0;
        repeat (3) @(negedge host_clk);
        host_rst = 1'b0;
        #1;
        chk("rst_run_mode", {63'd0, run_mode}, 64'd0);
        chk("rst_scan_mode", {63'd0, scan_mode}, 64'd0);
        chk("rst_pause_irq", {63'd0, pause_irq}, 64'd0);
        chk("rst_dma_dir", {63'd0, dma_direction}, 64'd0);
        rd("rst_mode_ctrl", 12'h000, 32'h0);
        rd("rst_tick_lo", 12'h008, 32'h0);
        model_busy = 1'b1;
        rd("model_busy", 12'h000, 32'h8);
        model_busy = 1'b0;

        // Step count expiry
        wr(12'h004, 32'd5);
        wr(12'h000, 32'h1);
        chk("step_running", {63'd0, run_mode}, 64'd1);
        ticks(4);
        chk("step_still_run", {63'd0, run_mode}, 64'd1);
        rd("step_cnt_1", 12'h004, 32'd1);
        ticks(1);
        chk("step_paused", {63'd0, run_mode}, 64'd0);
        chk("step_irq_hi", {63'd0, pause_irq}, 64'd1);
        @(negedge host_clk); #1;
        chk("step_irq_lo", {63'd0, pause_irq}, 64'd0);
        rd("step_cause", 12'h020, 32'h2);
        rd("step_tick_lo", 12'h008, 32'd5);
        rd("step_tick_hi", 12'h00C, 32'd0);
        rd("step_cnt_0", 12'h004, 32'd0);

        // Tick compare across 64-bit wrap
        wr(12'h008, 32'hFFFF_FFFE);
        wr(12'h00C, 32'hFFFF_FFFF);
        wr(12'h014, 32'd1);
        wr(12'h018, 32'd0);
        wr(12'h01C, 32'd1);
        wr(12'h000, 32'h1);
        rd("cmp_cause_clr", 12'h020, 32'h0);
        ticks(2);
        rd("cmp_wrap_lo", 12'h008, 32'd0);
        rd("cmp_wrap_hi", 12'h00C, 32'd0);
        chk("cmp_still_run", {63'd0, run_mode}, 64'd1);
        ticks(1);
        chk("cmp_paused", {63'd0, run_mode}, 64'd0);
        rd("cmp_cause", 12'h020, 32'h8);
        rd("cmp_tick_lo", 12'h008, 32'd1);
        wr(12'h01C, 32'd0);

        // Trigger stop, priority and status capture
        wr(12'h204, 32'h8);
        wr(12'h208, 32'h20);
        trig[69] = 1'b1; trig[35] = 1'b1; trig[0] = 1'b1;
        wr(12'h000, 32'h1);
        chk("trig_running", {63'd0, run_mode}, 64'd1);
        ticks(1);
        chk("trig_paused", {63'd0, run_mode}, 64'd0);
        rd("trig_cause", 12'h020, 32'h4);
        rd("trig_first", 12'h024, 32'h8000_0023);
        rd("trig_stat0", 12'h100, 32'h0);
        rd("trig_stat1", 12'h104, 32'h8);
        rd("trig_stat2", 12'h108, 32'h20);
        rd("trig_en2", 12'h208, 32'h20);
        rd("trig_en3_unmapped", 12'h20C, 32'h0);
        trig = '0;

        // Host stop waits for a tick
        wr(12'h000, 32'h1);
        rd("host_cause_clr", 12'h020, 32'h0);
        rd("host_first_clr", 12'h024, 32'h0);
        wr(12'h000, 32'h0);
        repeat (10) @(negedge host_clk);
        #1;
        chk("host_stopping_run", {63'd0, run_mode}, 64'd1);
        rd("host_pause_busy", 12'h000, 32'h5);
        ticks(1);
        chk("host_paused", {63'd0, run_mode}, 64'd0);
        rd("host_cause", 12'h020, 32'h1);

        // Write protection while running
        wr(12'h000, 32'h1);
        wr(12'h004, 32'd7);
        rd("prot_step", 12'h004, 32'd0);
        wr(12'h000, 32'h3);
        rd("prot_scan", 12'h000, 32'h1);
        @(negedge host_clk);
        ctrl_wen = 1'b1; ctrl_waddr = 12'h010; ctrl_wdata = 32'h1;
        #1;
        chk("prot_no_dma_start", {63'd0, dma_start}, 64'd0);
        @(negedge host_clk);
        ctrl_wen = 1'b0;
        wr(12'h000, 32'h0);
        ticks(1);
        chk("prot_paused", {63'd0, run_mode}, 64'd0);

        // Scan DMA control while paused
        @(negedge host_clk);
        ctrl_wen = 1'b1; ctrl_waddr = 12'h010; ctrl_wdata = 32'h1;
        #1;
        chk("dma_start_pulse", {63'd0, dma_start}, 64'd1);
        @(negedge host_clk);
        ctrl_wen = 1'b0;
        wr(12'h010, 32'h2);
        chk("dma_dir_set", {63'd0, dma_direction}, 64'd1);
        wr(12'h000, 32'h2);
        chk("scan_mode_set", {63'd0, scan_mode}, 64'd1);
        wr(12'h000, 32'h0);
        chk("scan_mode_clr", {63'd0, scan_mode}, 64'd0);
        dma_running = 1'b1;
        wr(12'h000, 32'h3);
        chk("dma_busy_no_run", {63'd0, run_mode}, 64'd0);
        chk("dma_busy_no_scan", {63'd0, scan_mode}, 64'd0);
        rd("scan_ctrl_rd", 12'h010, 32'h3);
        wr(12'h010, 32'h0);
        chk("dma_dir_held", {63'd0, dma_direction}, 64'd1);
        dma_running = 1'b0;

        // Edge bank
        wr(12'h300, 32'h8);
`ifdef EMU_TRIG_EDGE_EN
        rd("edge_bank", 12'h300, 32'h8);
        wr(12'h200, 32'h8);
        wr(12'h000, 32'h1);
        @(negedge host_clk); trig[3] = 1'b1; tick = 1'b1;
        @(negedge host_clk); tick = 1'b0;
        #1;
        chk("edge_paused", {63'd0, run_mode}, 64'd0);
        rd("edge_cause", 12'h020, 32'h4);
        ticks(2);
        wr(12'h000, 32'h1);
        ticks(3);
        chk("edge_no_repause", {63'd0, run_mode}, 64'd1);
        wr(12'h000, 32'h0);
        ticks(1);
        chk("edge_host_stop", {63'd0, run_mode}, 64'd0);
        trig = '0;
`else
        rd("edge_bank_absent", 12'h300, 32'h0);
`endif

        // Reset in the middle of a run
        wr(12'h000, 32'h1);
        chk("midrst_running", {63'd0, run_mode}, 64'd1);
        @(negedge host_clk); host_rst = 1'b1;
        @(negedge host_clk); host_rst = 1'b0;
        #1;
        chk("midrst_paused", {63'd0, run_mode}, 64'd0);
        chk("midrst_irq", {63'd0, pause_irq}, 64'd0);
        chk("midrst_dir", {63'd0, dma_direction}, 64'd0);
        @(negedge host_clk); #1;
        chk("midrst_irq_later", {63'd0, pause_irq}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
